// File: rtl/down_counter16_pkg.sv
// Shared types and constants for the loadable down counter / interval timer.
package down_counter16_pkg;

  localparam int unsigned DEFAULT_WIDTH = 16;
  localparam int unsigned COUNT_ZERO    = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : down_counter16_pkg

// File: rtl/down_counter16_if.sv
// Control/status bundle between a timer client (master) and down_counter16 (slave).
interface down_counter16_if
  import down_counter16_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) ();

  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             enable;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             zero;
  logic             tc;

  modport master (
    output load, load_value, enable,
    input  count, busy, zero, tc
  );

  modport slave (
    input  load, load_value, enable,
    output count, busy, zero, tc
  );

endinterface : down_counter16_if

// File: rtl/down_counter16_core.sv
// Count register with load, saturating decrement by STEP, and at-or-below-STEP compare.
module down_counter16_core
  import down_counter16_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned STEP  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  input  logic             dec,
  output logic [WIDTH-1:0] cnt,
  output logic             term
);

  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] ZERO_W = WIDTH'(COUNT_ZERO);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  // term flags that the next decrement would reach or pass zero
  always_comb begin
    term  = (cnt_q <= STEP_W);
    cnt_d = cnt_q;
    if (ld) begin
      cnt_d = ld_val;
    end else if (dec) begin
      cnt_d = term ? ZERO_W : (cnt_q - STEP_W);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= ZERO_W;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule : down_counter16_core

// File: rtl/down_counter16.sv
// Loadable down counter / timer with one-cycle terminal-count pulse.
// Define DOWN_COUNTER16_AUTORELOAD_EN for periodic reload instead of one-shot.
module down_counter16
  import down_counter16_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned STEP  = 1
) (
  input  logic               clock0,
  input  logic               reset,
  down_counter16_if.slave    bus
);

  localparam logic [WIDTH-1:0] ZERO_W = WIDTH'(COUNT_ZERO);

  state_e           state_q, state_d;
  logic             tc_q, tc_d;
  logic             busy_q;
  logic             core_ld, core_dec, core_term;
  logic [WIDTH-1:0] core_val, core_cnt;

`ifdef DOWN_COUNTER16_AUTORELOAD_EN
  logic [WIDTH-1:0] reload_q, reload_d;
`endif

  down_counter16_core #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_core (
    .clk    (clock0),
    .rst_n  (reset),
    .ld     (core_ld),
    .ld_val (core_val),
    .dec    (core_dec),
    .cnt    (core_cnt),
    .term   (core_term)
  );

  // Load beats any decrement; only RUN with enable advances the count
  always_comb begin
    state_d  = state_q;
    tc_d     = 1'b0;
    core_ld  = 1'b0;
    core_dec = 1'b0;
    core_val = bus.load_value;
`ifdef DOWN_COUNTER16_AUTORELOAD_EN
    reload_d = bus.load ? bus.load_value : reload_q;
`endif
    if (bus.load) begin
      core_ld = 1'b1;
      state_d = (bus.load_value != ZERO_W) ? RUN : IDLE;
    end else begin
      unique case (state_q)
        IDLE: state_d = IDLE;
        RUN: begin
          if (bus.enable) begin
            if (core_term) begin
              tc_d = 1'b1;
`ifdef DOWN_COUNTER16_AUTORELOAD_EN
              core_ld  = 1'b1;
              core_val = reload_q;
`else
              core_dec = 1'b1;
              state_d  = DONE;
`endif
            end else begin
              core_dec = 1'b1;
            end
          end
        end
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock0 or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      tc_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tc_q    <= tc_d;
      busy_q  <= (state_d == RUN);
    end
  end

`ifdef DOWN_COUNTER16_AUTORELOAD_EN
  always_ff @(posedge clock0 or negedge reset) begin
    if (!reset) begin
      reload_q <= ZERO_W;
    end else begin
      reload_q <= reload_d;
    end
  end
`endif

  assign bus.count = core_cnt;
  assign bus.busy  = busy_q;
  assign bus.tc    = tc_q;
  assign bus.zero  = (core_cnt == ZERO_W);

endmodule : down_counter16

// File: doc/down_counter16.md
Name: down_counter16

Overview:
- Loadable 16-bit down counter and timer. It is the count-down counterpart of the team's free-running up counter.
- Software or another FSM loads a start value, gates decrements with enable, and receives a single-cycle terminal-count pulse when the count reaches zero.
- Used as an interval timer or a timeout generator next to the up counters in the simple_registers group.

Parameters:
- WIDTH, 16, width of count and load_value.
- STEP, 1, decrement amount per enabled cycle (unsigned, must be at least 1).

Ports:
- clock0  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; clears all state immediately, independent of clock0.
- load  in  1  level, sampled on the clock edge; loads load_value.
- load_value  in  WIDTH  start value, sampled only when load=1.
- enable  in  1  decrement gate, meaningful in RUN only.
- count  out  WIDTH  current counter register.
- busy  out  1  high while state is RUN.
- zero  out  1  combinational, count==0.
- tc  out  1  registered terminal-count pulse, exactly one cycle wide.

Behaviour:
- Reset (reset=0, asynchronous): count=0, state=IDLE, busy=0, tc=0, zero=1. Reset asserted mid-count aborts the count immediately. After release, the first clock0 edge behaves as IDLE.
- States: IDLE, RUN, DONE. busy is 1 if and only if state is RUN.
- Load priority: load has priority over decrement in every state. On load, count takes load_value on the next edge and tc is 0 that cycle.
  - load_value != 0: next state is RUN.
  - load_value == 0: next state is IDLE, and no tc is generated.
- IDLE: count holds, enable is ignored.
- RUN, enable=0: count holds, with no timeout.
- RUN, enable=1, count > STEP: count <= count - STEP.
- RUN, enable=1, count <= STEP: count <= 0, tc <= 1, state <= DONE. The count saturates at 0 and never wraps below zero.
  - tc is high in the same cycle that count first reads 0.
- DONE: count holds at 0, tc returns to 0 after one cycle, busy=0. The block stays in DONE until load.
- enable and load together: load wins, and the pending decrement is discarded.
- Latency: load to count valid is 1 cycle. With enable held high and STEP=1, a load of value N produces tc exactly N cycles after the first enabled RUN edge.
- Arithmetic: unsigned WIDTH-bit. STEP is truncated to WIDTH bits.

Optional Feature:
- Macro: DOWN_COUNTER16_AUTORELOAD_EN.
- Defined:
  - A WIDTH-bit reload register captures load_value on every load.
  - At the terminal condition in RUN, count <= reload (not 0), tc pulses, and the state stays RUN. This gives a periodic tc every N enabled cycles (STEP=1); count never reads 0 in steady state.
  - A load of 0 stops the timer, and the state goes to IDLE.
  - The reload register resets to 0.
- Undefined: the one-shot behaviour above. No reload register is synthesized.

Decomposition:
- Shared package down_counter16_pkg holds:
  - the state enumeration typedef (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - the default WIDTH constant;
  - the COUNT_ZERO localparam.
- One natural sub-module, down_counter16_core: the count register plus saturating decrement and terminal-compare logic. It has inputs ld, ld_val, dec and outputs cnt and term.
- The top level holds the FSM, tc register and optional reload register.

Test Plan:
- Reset: assert reset mid-RUN with count=0x1234, no clock edge → count=0, busy=0, tc=0, zero=1 immediately.
- One-shot: load 5, enable held 1 → count 5,4,3,2,1,0; tc high only in the cycle count=0; state DONE; count stays 0 for 10 more cycles.
- Gating: load 3; enable pattern 1,0,0,1,1 → count 3,2,2,2,1,0; tc exactly once.
- Load priority: in RUN at count=7 assert load=1, load_value=0x00FF, enable=1 → next count=0x00FF with no decrement and tc=0. load_value=0 → IDLE, no tc.
- Saturation: STEP=4, load 6, enable 1 → count 6,2,0; tc once; no wrap to 0xFFFE.
- Autoreload (macro defined): load 3, enable 1 → count 3,2,1,3,2,1,…; tc every 3rd cycle; busy stays 1. A load of 0 → IDLE, busy=0.
